// File: rtl/sram2_arb_pkg.sv
// sram2_arb_pkg: shared types and default widths for the SRAM2 access controller
package sram2_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_LSU, OWN_DMA} owner_e;
endpackage

// File: rtl/sram2_port2_arb.sv
// sram2_port2_arb: LSU-priority grant for port 2 with DMA aging so DMA cannot starve
module sram2_port2_arb
  import sram2_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lsu_req,
  input  logic dma_req,
  output logic lsu_gnt,
  output logic dma_gnt
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  assign dma_gnt = rst_n && dma_req && (!lsu_req || wait_cnt == CW'(MAX_WAIT));
  assign lsu_gnt = rst_n && lsu_req && !dma_gnt;
  // count consecutive denied DMA cycles, restart once DMA wins or drops its request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (!dma_req || dma_gnt) ? '0 : (wait_cnt == CW'(MAX_WAIT) ? wait_cnt : wait_cnt + CW'(1));
endmodule

// File: rtl/sram2_arbiter.sv
// sram2_arbiter: shares the dual-read-port SRAM2 macro among IF, LSU and DMA
module sram2_arbiter
  import sram2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [BE_W-1:0]   lsu_be,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [BE_W-1:0]   dma_be,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [BE_W-1:0]   sram_ben,
  output logic [ADDR_W-1:0] sram_addr1,
  output logic [ADDR_W-1:0] sram_addr2,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout1,
  input  logic [DATA_W-1:0] sram_dout2
);
  owner_e            p2_own;
  logic              if_pend;
  logic              p2_we;
  logic [BE_W-1:0]   p2_be;
  logic [DATA_W-1:0] if_hold, lsu_hold, dma_hold;
  sram2_port2_arb #(.MAX_WAIT(MAX_WAIT)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .lsu_req (lsu_req),
    .dma_req (dma_req),
    .lsu_gnt (lsu_gnt),
    .dma_gnt (dma_gnt)
  );
  assign if_gnt = rst_n && if_req;
  assign sram_addr1 = if_addr;
  // steer the port-2 winner onto the macro pins; idle port 2 drives zeros
  always_comb begin
    p2_we = lsu_gnt ? lsu_we : dma_gnt && dma_we;
    p2_be = lsu_gnt ? lsu_be : dma_be;
    sram_addr2 = lsu_gnt ? lsu_addr : dma_gnt ? dma_addr : '0;
    sram_din = lsu_gnt ? lsu_wdata : dma_gnt ? dma_wdata : '0;
    sram_cen = !(if_gnt || lsu_gnt || dma_gnt);
    sram_wen = !p2_we;
    sram_ben = p2_we ? ~p2_be : '1;
  end
  // remember who owns the read data arriving next cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      if_pend <= 1'b0;
      p2_own <= OWN_NONE;
    end else begin
      if_pend <= if_gnt;
      p2_own <= lsu_gnt ? OWN_LSU : dma_gnt ? OWN_DMA : OWN_NONE;
    end
  assign if_rvalid = if_pend;
  assign lsu_rvalid = p2_own == OWN_LSU;
  assign dma_rvalid = p2_own == OWN_DMA;
  assign if_rdata = if_rvalid ? sram_dout1 : if_hold;
  assign lsu_rdata = lsu_rvalid ? sram_dout2 : lsu_hold;
  assign dma_rdata = dma_rvalid ? sram_dout2 : dma_hold;
  // keep each owner's last response since the macro zeroes its outputs when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      if_hold <= '0;
      lsu_hold <= '0;
      dma_hold <= '0;
    end else begin
      if (if_rvalid) if_hold <= sram_dout1;
      if (lsu_rvalid) lsu_hold <= sram_dout2;
      if (dma_rvalid) dma_hold <= sram_dout2;
    end
endmodule

// File: tb/tb_sram2_arbiter.sv
// tb_sram2_arbiter: vector table plus scoreboard bench for sram2_arbiter with an SRAM2 model
module tb_sram2_arbiter;
  logic clk = 1'b0, rst_n;
  logic if_req, if_gnt, if_rvalid;
  logic [15:0] if_addr;
  logic [31:0] if_rdata;
  logic lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [3:0] lsu_be;
  logic [15:0] lsu_addr;
  logic [31:0] lsu_wdata, lsu_rdata;
  logic dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [3:0] dma_be;
  logic [15:0] dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic sram_cen, sram_wen;
  logic [3:0] sram_ben;
  logic [15:0] sram_addr1, sram_addr2;
  logic [31:0] sram_din, sram_dout1, sram_dout2;
  logic load_en;
  logic [7:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] q_if[$], q_l[$], q_d[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  sram2_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
    .sram_addr1(sram_addr1), .sram_addr2(sram_addr2), .sram_din(sram_din),
    .sram_dout1(sram_dout1), .sram_dout2(sram_dout2)
  );

  // SRAM2 macro: registered outputs, read-before-write, outputs zero when deselected
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (!sram_cen) begin
      sram_dout1 <= mem[sram_addr1[7:0]];
      sram_dout2 <= mem[sram_addr2[7:0]];
      if (!sram_wen)
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) mem[sram_addr2[7:0]][b*8 +: 8] <= sram_din[b*8 +: 8];
    end else begin
      sram_dout1 <= '0;
      sram_dout2 <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    if_req = 0; if_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_be = '0; lsu_addr = '0; lsu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_be = '0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en = 1; load_addr = a; load_data = d;
    nxt();
  endtask

  // scoreboard: responses checked against expectations queued at acceptance
  initial forever begin
    smp();
    if (!rst_n) begin
      q_if.delete(); q_l.delete(); q_d.delete();
      chk("rst_rvalids", 32'({if_rvalid, lsu_rvalid, dma_rvalid}), 32'(0));
    end else begin
      chk("sb_if_valid", 32'(if_rvalid), 32'(q_if.size()));
      chk("sb_lsu_valid", 32'(lsu_rvalid), 32'(q_l.size()));
      chk("sb_dma_valid", 32'(dma_rvalid), 32'(q_d.size()));
      if (q_if.size() > 0) chk("sb_if_data", if_rdata, q_if.pop_front());
      if (q_l.size() > 0) chk("sb_lsu_data", lsu_rdata, q_l.pop_front());
      if (q_d.size() > 0) chk("sb_dma_data", dma_rdata, q_d.pop_front());
      if (if_gnt) q_if.push_back(shadow[if_addr[7:0]]);
      if (lsu_gnt) begin
        q_l.push_back(shadow[lsu_addr[7:0]]);
        if (lsu_we) for (int b = 0; b < 4; b++) if (lsu_be[b]) shadow[lsu_addr[7:0]][b*8 +: 8] = lsu_wdata[b*8 +: 8];
      end
      if (dma_gnt) begin
        q_d.push_back(shadow[dma_addr[7:0]]);
        if (dma_we) for (int b = 0; b < 4; b++) if (dma_be[b]) shadow[dma_addr[7:0]][b*8 +: 8] = dma_wdata[b*8 +: 8];
      end
    end
    if (load_en) shadow[load_addr] = load_data;
  end

  typedef struct packed {
    logic ifr, lr, lw;
    logic [3:0] lbe;
    logic dr, dw;
    logic [3:0] dbe;
    logic [2:0] g;
    logic cen, wen;
    logic [3:0] ben;
    logic [15:0] a2;
  } vec_t;
  vec_t tv [10];

  initial begin
    tv[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 1'b1, 4'hF, 16'h0000};
    tv[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'b100, 1'b0, 1'b1, 4'hF, 16'h0000};
    tv[2] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'b010, 1'b0, 1'b1, 4'hF, 16'h0040};
    tv[3] = '{1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 3'b010, 1'b0, 1'b0, 4'hA, 16'h0040};
    tv[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 3'b001, 1'b0, 1'b0, 4'hC, 16'h0041};
    tv[5] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 3'b010, 1'b0, 1'b1, 4'hF, 16'h0040};
    tv[6] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 3'b110, 1'b0, 1'b0, 4'hF, 16'h0040};
    tv[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'b101, 1'b0, 1'b1, 4'hF, 16'h0041};
    tv[8] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 3'b101, 1'b0, 1'b0, 4'h0, 16'h0041};
    tv[9] = '{1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 3'b001, 1'b0, 1'b1, 4'hF, 16'h0041};
    rst_n = 0; load_en = 0; load_addr = '0; load_data = '0;
    idle();
    if_req = 1; lsu_req = 1; lsu_we = 1; lsu_be = 4'hF; dma_req = 1; dma_we = 1; dma_be = 4'hF;
    smp();
    chk("rst_gnts", 32'({if_gnt, lsu_gnt, dma_gnt}), 32'(0));
    chk("rst_cen", 32'(sram_cen), 32'(1));
    chk("rst_wen", 32'(sram_wen), 32'(1));
    chk("rst_ben", 32'(sram_ben), 32'hF);
    chk("rst_rdata", if_rdata | lsu_rdata | dma_rdata, 32'h0);
    idle();
    nxt();
    for (int i = 0; i < 256; i++) load(8'(i), 32'hC0DE0000 | 32'(i));
    load(8'h10, 32'hDEADBEEF);
    load(8'h20, 32'hAAAAAAAA);
    load(8'h30, 32'h12345678);
    load_en = 0;
    rst_n = 1;
    nxt();
    for (int i = 0; i < 10; i++) begin
      if_req = tv[i].ifr; if_addr = 16'h0042;
      lsu_req = tv[i].lr; lsu_we = tv[i].lw; lsu_be = tv[i].lbe; lsu_addr = 16'h0040; lsu_wdata = 32'h11110000 + 32'(i);
      dma_req = tv[i].dr; dma_we = tv[i].dw; dma_be = tv[i].dbe; dma_addr = 16'h0041; dma_wdata = 32'h22220000 + 32'(i);
      smp();
      chk($sformatf("v%0d_gnts", i), 32'({if_gnt, lsu_gnt, dma_gnt}), 32'(tv[i].g));
      chk($sformatf("v%0d_cen", i), 32'(sram_cen), 32'(tv[i].cen));
      chk($sformatf("v%0d_wen", i), 32'(sram_wen), 32'(tv[i].wen));
      chk($sformatf("v%0d_ben", i), 32'(sram_ben), 32'(tv[i].ben));
      chk($sformatf("v%0d_addr2", i), 32'(sram_addr2), 32'(tv[i].a2));
      nxt();
      idle();
      smp();
      nxt();
    end
    if_req = 1; if_addr = 16'h0010;
    smp();
    chk("ifrd_addr1", 32'(sram_addr1), 32'h10);
    nxt();
    idle();
    smp();
    chk("ifrd_rvalid", 32'(if_rvalid), 32'(1));
    chk("ifrd_rdata", if_rdata, 32'hDEADBEEF);
    nxt();
    smp();
    chk("ifrd_rvalid_once", 32'(if_rvalid), 32'(0));
    chk("ifrd_hold", if_rdata, 32'hDEADBEEF);
    chk("idle_cen", 32'(sram_cen), 32'(1));
    chk("idle_ben", 32'(sram_ben), 32'hF);
    chk("idle_din", sram_din, 32'h0);
    nxt();
    lsu_req = 1; lsu_we = 1; lsu_be = 4'b0101; lsu_addr = 16'h0020; lsu_wdata = 32'h11223344;
    smp();
    chk("lw_din", sram_din, 32'h11223344);
    nxt();
    lsu_we = 0; lsu_be = '0;
    smp();
    chk("lw_ack_valid", 32'(lsu_rvalid), 32'(1));
    chk("lw_ack_old", lsu_rdata, 32'hAAAAAAAA);
    nxt();
    idle();
    smp();
    chk("lr_merged", lsu_rdata, 32'hAA22AA44);
    nxt();
    lsu_req = 1; lsu_addr = 16'h0050; dma_req = 1; dma_addr = 16'h0060;
    for (int k = 0; k < 10; k++) begin
      smp();
      chk($sformatf("age%0d_lsu", k), 32'(lsu_gnt), 32'(k % 5 != 4));
      chk($sformatf("age%0d_dma", k), 32'(dma_gnt), 32'(k % 5 == 4));
      chk($sformatf("age%0d_excl", k), 32'(lsu_gnt & dma_gnt), 32'(0));
      nxt();
    end
    idle();
    smp();
    nxt();
    if_req = 1; if_addr = 16'h0030;
    lsu_req = 1; lsu_we = 1; lsu_be = 4'hF; lsu_addr = 16'h0030; lsu_wdata = 32'h00000055;
    smp();
    chk("raw_gnts", 32'({if_gnt, lsu_gnt, dma_gnt}), 32'b110);
    nxt();
    idle();
    smp();
    chk("raw_if_old", if_rdata, 32'h12345678);
    chk("raw_lsu_old", lsu_rdata, 32'h12345678);
    nxt();
    if_req = 1; if_addr = 16'h0030;
    nxt();
    idle();
    smp();
    chk("raw_if_new", if_rdata, 32'h00000055);
    nxt();
    dma_req = 1; dma_addr = 16'h0010;
    smp();
    chk("rstmid_dma_gnt", 32'(dma_gnt), 32'(1));
    nxt();
    rst_n = 0;
    idle();
    dma_req = 1;
    smp();
    chk("rstmid_dma_rvalid", 32'(dma_rvalid), 32'(0));
    chk("rstmid_dma_rdata", dma_rdata, 32'h0);
    chk("rstmid_if_rdata", if_rdata, 32'h0);
    chk("rstmid_dma_gnt_forced", 32'(dma_gnt), 32'(0));
    chk("rstmid_cen", 32'(sram_cen), 32'(1));
    nxt();
    dma_req = 0;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("post%0d_dma_rvalid", k), 32'(dma_rvalid), 32'(0));
      chk($sformatf("post%0d_cen", k), 32'(sram_cen), 32'(1));
      nxt();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram2_arbiter.md
# sram2_arbiter

Access controller in front of the dual-read-port `SRAM2` macro, sharing it among three requesters: instruction fetch (IF) on dedicated read port 1, and load/store unit (LSU) and DMA/loader competing for read/write port 2. Drives the macro's active-low `cen`/`wen`/`ben` and routes each 1-cycle-latency read back to its owner. Arbitration on port 2 is LSU-priority with DMA aging, so DMA cannot starve.

## Interface
- `ADDR_W`, 16, word address width (equals SRAM `$clog2(DEPTH)`).
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` = 4 bits.
- `MAX_WAIT`, 4, consecutive denied DMA cycles before DMA is forced to win.

- `clk` in 1: single clock; everything rising-edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `if_req` in 1, `if_addr` in ADDR_W: IF read request.
- `if_gnt` out 1: accept; `if_rvalid` out 1, `if_rdata` out DATA_W: response.
- `lsu_req`, `lsu_we` in 1; `lsu_be` in 4 (active-high); `lsu_addr` in ADDR_W; `lsu_wdata` in DATA_W.
- `lsu_gnt`, `lsu_rvalid` out 1; `lsu_rdata` out DATA_W.
- `dma_req`, `dma_we`, `dma_be`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same as LSU.
- `sram_cen`, `sram_wen` out 1 (active-low); `sram_ben` out 4 (active-low).
- `sram_addr1`, `sram_addr2` out ADDR_W; `sram_din` out DATA_W.
- `sram_dout1`, `sram_dout2` in DATA_W: macro registered outputs.

## Operation
- Request accepted at the rising edge where `req && gnt`; grants are combinational from the same-cycle requests. Responses cannot be back-pressured.
- IF: `if_gnt = if_req`. `sram_addr1 = if_addr`.
- Port 2: `dma_gnt` when `dma_req && (!lsu_req || wait_cnt == MAX_WAIT)`, else `lsu_gnt = lsu_req`. At most one port-2 grant per cycle.
- `wait_cnt`: increments while `dma_req && !dma_gnt`; clears on DMA grant or `dma_req` low; saturates at MAX_WAIT.
- `sram_cen = !(if_gnt | lsu_gnt | dma_gnt)`. `sram_addr2`/`sram_din` come from the port-2 winner; zero when idle.
- `sram_wen = !(port-2 grant && we)`. `sram_ben = ~be` on a write, `4'hF` otherwise. A write with `be == 0` still acks.
- Owner register `p2_own` ∈ {NONE, LSU, DMA}, plus `if_pend`, capture each accepted request.
- Response cycle: `<owner>_rvalid = 1` and `<owner>_rdata = sram_dout` for the matching port.
  - Writes also get `rvalid`; their `rdata` is the pre-write word (read-before-write).
- `if_rdata`, `lsu_rdata`, `dma_rdata` are holding registers. Each keeps its last response value until the next response for that owner, because the macro zeroes its outputs when `cen` is high.

## Timing
- Latency: request accepted in cycle N, `rvalid` high for exactly cycle N+1. Back-to-back requests give one response per cycle.
- Reset values: all `rvalid` 0, all `rdata` 0, `p2_own` NONE, `if_pend` 0, `wait_cnt` 0.
  - While `rst_n` is low, all grants are forced 0, `sram_cen` = 1, `sram_wen` = 1, `sram_ben` = 4'hF.
- Reset mid-operation: the pending response is discarded, and no `rvalid` appears after release.
- IF plus LSU/DMA in the same cycle: both proceed; `cen` is shared.
- LSU write and IF read to the same address in the same cycle: IF gets the old word.
- DMA aging: with LSU requesting continuously and `MAX_WAIT=4`, DMA is denied 4 cycles and granted on the 5th. LSU is denied that one cycle, then `wait_cnt` restarts.

## Structure
- Package `sram2_arb_pkg`: `owner_e` {OWN_NONE, OWN_LSU, OWN_DMA}, default widths, `BE_W` constant.
- Sub-module `sram2_port2_arb`: LSU/DMA grant logic plus `wait_cnt`. The top holds the owner and response registers and the SRAM drive.

## Test plan
- IF reads addr 0x0010 (preloaded 0xDEADBEEF) -> `if_rvalid` 1 cycle later with 0xDEADBEEF; `if_rdata` holds the value while idle.
- LSU writes 0x11223344 with `be=4'b0101` to 0x0020 over 0xAAAAAAAA, then reads it -> write ack `rdata` 0xAAAAAAAA, read returns 0xAA22AA44.
- LSU and DMA request continuously (`MAX_WAIT=4`) -> grant pattern L,L,L,L,D repeating; no cycle has two port-2 grants.
- IF reads 0x0030 while LSU writes 0x55 to 0x0030 in the same cycle -> IF gets the old word; a later IF read gets the new one.
- Reset asserted the cycle after a DMA read is accepted -> no `dma_rvalid` after release; all outputs at reset values; `sram_cen` stays 1.
- No requests -> `sram_cen` 1, `sram_ben` 4'hF, all `rdata` unchanged.
